// File: rtl/fp_serializer_if.sv
// rtl/fp_serializer_if.sv - handshake and serial-line bundle for fp_serializer
//
// Purpose: groups the word handshake (in_valid/in_ready with s/e/f) and the
// serial-side outputs (tx, busy, frame_done) so they travel as one port.
//
// Signals:
//   in_valid   - producer presents a float word on s/e/f
//   in_ready   - serializer can accept a word this cycle
//   s, e, f    - sign, 3-bit exponent, 4-bit significand
//   tx         - serial line, idle high
//   busy       - a frame is in progress
//   frame_done - one-cycle pulse in the final cycle of a frame
//
// master: the word producer.  slave: the serializer.

interface fp_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic       s;
  logic [2:0] e;
  logic [3:0] f;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output in_valid, s, e, f,
    input  in_ready, tx, busy, frame_done
  );

  modport slave (
    input  in_valid, s, e, f,
    output in_ready, tx, busy, frame_done
  );
endinterface

// File: rtl/fp_serializer.sv
// rtl/fp_serializer.sv - 11-bit framed serializer for 8-bit float words
//
// Purpose: accepts a {s, e, f} float word through a valid/ready handshake and
// sends it on tx as: start(0), 8 data bits MSB first, even parity, stop(1).
// Every bit is held for CLKS_PER_BIT clk cycles.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit (1..65535)
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; forces tx high and aborts a frame
//   bus  - fp_serializer_if.slave: in_valid/in_ready/s/e/f in,
//          tx/busy/frame_done out

module fp_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  fp_serializer_if.slave  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // The baud counter counts down to zero; zero marks the last cycle of a bit.
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic        r_tx;

  logic        w_idle;
  logic        w_accept;
  logic        w_bit_end;
  logic [7:0]  w_byte;

  assign w_byte    = {bus.s, bus.e, bus.f};
  assign w_idle    = (r_state == IDLE);
  assign w_accept  = w_idle && bus.in_valid;
  assign w_bit_end = (r_baud == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= 8'd0;
      r_parity <= 1'b0;
      r_baud   <= 16'd0;
      r_bit    <= 3'd0;
      r_tx     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Parity is taken from the captured byte so later changes on
            // s/e/f cannot reach the frame.
            r_state  <= START;
            r_shift  <= w_byte;
            r_parity <= ^w_byte;
            r_baud   <= BAUD_RELOAD;
            r_bit    <= 3'd0;
            r_tx     <= 1'b0;
          end
        end

        START: begin
          if (w_bit_end) begin
            // The shifter always presents the next bit in its MSB, so moving
            // to a new data bit is "drive MSB, shift left".
            r_state <= DATA;
            r_tx    <= r_shift[7];
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= 3'd0;
            r_baud  <= BAUD_RELOAD;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit == 3'd7) begin
              r_state <= PARITY;
              r_tx    <= r_parity;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[7];
              r_shift <= {r_shift[6:0], 1'b0};
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
            r_baud  <= BAUD_RELOAD;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            // Returning to IDLE costs one cycle, which gives the idle-high
            // gap between back-to-back frames.
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_bit   <= 3'd0;
            r_baud  <= 16'd0;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_baud  <= 16'd0;
          r_bit   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_idle;
  assign bus.busy       = ~w_idle;
  assign bus.tx         = r_tx;
  // Decoded from registers only: high for the last cycle of STOP.
  assign bus.frame_done = (r_state == STOP) && w_bit_end;

endmodule

// File: tb/tb_fp_serializer.sv
// tb/tb_fp_serializer.sv - self-checking bench for fp_serializer (CLKS_PER_BIT 4 and 1)

module tb_fp_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       drv_valid [2];
  logic [7:0] drv_byte  [2];

  wire [1:0] tx_w;
  wire [1:0] rdy_w;
  wire [1:0] busy_w;
  wire [1:0] done_w;

  int qsize      [2];
  int acc_cnt    [2];
  int model_done [2];
  int done_cnt   [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int CPB = (g == 0) ? 4 : 1;

    fp_serializer_if bus ();

    fp_serializer #(.CLKS_PER_BIT(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.in_valid = drv_valid[g];
    assign bus.s        = drv_byte[g][7];
    assign bus.e        = drv_byte[g][6:4];
    assign bus.f        = drv_byte[g][3:0];
    assign tx_w[g]      = bus.tx;
    assign rdy_w[g]     = bus.in_ready;
    assign busy_w[g]    = bus.busy;
    assign done_w[g]    = bus.frame_done;

    // Reference: a queue of the tx level expected in each remaining cycle of
    // the current frame. Empty queue means the block is idle and ready.
    bit         exp_q [$];
    logic [7:0] m_byte;
    logic [10:0] m_frame;

    initial begin
      qsize[g]      = 0;
      acc_cnt[g]    = 0;
      model_done[g] = 0;
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          exp_q.delete();
        end else if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) model_done[g]++;
        end else if (drv_valid[g]) begin
          m_byte  = drv_byte[g];
          m_frame = {1'b0, m_byte, ^m_byte, 1'b1};
          for (int i = 10; i >= 0; i--)
            for (int c = 0; c < CPB; c++)
              exp_q.push_back(m_frame[i]);
          acc_cnt[g]++;
        end
        qsize[g] = exp_q.size();
      end
    end

    initial begin
      done_cnt[g] = 0;
      forever begin
        @(negedge clk);
        if (done_w[g] === 1'b1) done_cnt[g]++;
        check_val($sformatf("l%0d_tx", g),    tx_w[g],   (exp_q.size() != 0) ? exp_q[0] : 1'b1);
        check_val($sformatf("l%0d_ready", g), rdy_w[g],  exp_q.size() == 0);
        check_val($sformatf("l%0d_busy", g),  busy_w[g], exp_q.size() != 0);
        check_val($sformatf("l%0d_done", g),  done_w[g], exp_q.size() == 1);
      end
    end
  end

  task automatic wait_idle(input int ln);
    int n;
    n = 0;
    while (qsize[ln] != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", n < 300, 1);
  endtask

  // Sends one word and compares tx against an explicit bit pattern (MSB first).
  task automatic send_pattern(input int ln, input logic [7:0] b, input logic [10:0] pat);
    int c;
    c = (ln == 0) ? 4 : 1;
    wait_idle(ln);
    drv_byte[ln]  = b;
    drv_valid[ln] = 1'b1;
    @(negedge clk);
    drv_valid[ln] = 1'b0;
    for (int k = 0; k < 11 * c; k++) begin
      check_val("pat_tx", tx_w[ln], pat[10 - k / c]);
      check_val("pat_done", done_w[ln], k == 11 * c - 1);
      if (k != 11 * c - 1) @(negedge clk);
    end
  endtask

  int base;
  int idle_n;

  initial begin
    for (int ln = 0; ln < 2; ln++) begin
      drv_valid[ln] = 1'b0;
      drv_byte[ln]  = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_tx",    tx_w,   2'b11);
    check_val("rst_ready", rdy_w,  2'b11);
    check_val("rst_busy",  busy_w, 2'b00);
    check_val("rst_done",  done_w, 2'b00);
    rst = 1'b0;

    // 0x59 and 0x80 with explicit frames
    send_pattern(0, 8'h59, 11'b00101100101);
    send_pattern(0, 8'h80, 11'b01000000011);

    // back-to-back with in_valid held: 0xFF then 0x00
    wait_idle(0);
    base   = acc_cnt[0];
    idle_n = 0;
    drv_byte[0]  = 8'hFF;
    drv_valid[0] = 1'b1;
    for (int n = 0; n < 200 && acc_cnt[0] < base + 2; n++) begin
      @(negedge clk);
      if (acc_cnt[0] == base + 1) begin
        drv_byte[0] = 8'h00;
        if (rdy_w[0] === 1'b1) idle_n++;
      end
    end
    drv_valid[0] = 1'b0;
    check_val("b2b_accepts", acc_cnt[0] - base, 2);
    check_val("b2b_idle_gap", idle_n, 1);

    // inputs toggling while busy
    wait_idle(0);
    drv_byte[0]  = 8'($urandom);
    drv_valid[0] = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 50; n++) begin
      drv_byte[0]  = 8'($urandom);
      drv_valid[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    drv_valid[0] = 1'b0;
    wait_idle(0);

    // reset during DATA bit 3, then a clean frame after release
    drv_byte[0]  = 8'h3C;
    drv_valid[0] = 1'b1;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_tx",    tx_w[0],   1);
    check_val("async_rst_ready", rdy_w[0],  1);
    check_val("async_rst_done",  done_w[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("abort_done_total", done_cnt[0], model_done[0]);
    send_pattern(0, 8'hC3, 11'b01100001101);

    // one bit per cycle
    send_pattern(1, 8'hA5, 11'b01010010101);

    // random traffic on both lanes
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int ln = 0; ln < 2; ln++) begin
        drv_valid[ln] = ($urandom_range(0, 9) < 3);
        drv_byte[ln]  = 8'($urandom);
      end
      @(negedge clk);
    end
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    @(negedge clk);
    check_val("l0_done_total", done_cnt[0], model_done[0]);
    check_val("l1_done_total", done_cnt[1], model_done[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_serializer.md
FP_SERIALIZER -- requirements
Module: fp_serializer

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 4, meaning the number of clk cycles each serial bit is held on tx (legal range 1..65535).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1: a float word is presented on s/e/f.
REQ-005 The module SHALL have port in_ready, output, 1: the block can accept a word this cycle.
REQ-006 The module SHALL have port s, input, 1: sign of the float word from the converter stage.
REQ-007 The module SHALL have port e, input, 3: exponent of the float word.
REQ-008 The module SHALL have port f, input, 4: significand of the float word.
REQ-009 The module SHALL have port tx, output, 1: the serial line, idle high.
REQ-010 The module SHALL have port busy, output, 1: a frame is in progress.
REQ-011 The module SHALL have port frame_done, output, 1: single-cycle pulse at the end of a frame.

Function
REQ-012 The data byte SHALL be {s, e[2:0], f[3:0]}, transmitted MSB first (s first, f[0] last).
REQ-013 The frame SHALL be 11 bits: start (0), 8 data bits, even parity bit (XOR of the 8 data bits), stop (1).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 in_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of in_ready.
REQ-016 A transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1: the byte is captured into a shift register and the FSM enters START.
REQ-017 tx SHALL be a registered output: 1 in IDLE, 0 in START, the current data bit in DATA, parity in PARITY, 1 in STOP.
REQ-018 tx SHALL go low on the same edge as the accepting transfer.
REQ-019 Each of the 11 bits SHALL be held for exactly CLKS_PER_BIT cycles, using a baud counter that reloads at every bit boundary.
REQ-020 A 3-bit bit counter SHALL index DATA; DATA SHALL exit to PARITY after bit index 7 completes.
REQ-021 Parity SHALL be computed from the captured byte, never from the live s/e/f inputs.
REQ-022 frame_done SHALL be high for exactly the final clk cycle of STOP.
REQ-023 After STOP the FSM SHALL enter IDLE, so the minimum spacing between frames is 11*CLKS_PER_BIT+1 cycles start-to-start.
REQ-024 Changes on s/e/f/in_valid while busy=1 SHALL be ignored and SHALL NOT be latched later.
REQ-025 With CLKS_PER_BIT=1 the block SHALL produce one bit per cycle without skipped or repeated bits.
REQ-026 in_valid held high continuously SHALL cause back-to-back frames, each capturing the word present in its own IDLE cycle.

Reset
REQ-027 While rst=1 the FSM SHALL be in IDLE, with tx=1, in_ready=1, busy=0, frame_done=0, and all counters and the shift register 0.
REQ-028 rst asserted mid-frame SHALL force tx=1 immediately (asynchronously) and abort the frame with no frame_done pulse.
REQ-029 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-030 CLKS_PER_BIT=4; s=0, e=101, f=1001 (byte 0x59) -> tx sequence 0,0,1,0,1,1,0,0,1,0,1, each held 4 cycles; frame_done once at cycle 44 after accept.
REQ-031 s=1, e=000, f=0000 (byte 0x80) -> data bits 1,0,0,0,0,0,0,0, parity 1, stop 1.
REQ-032 s=1, e=111, f=1111 (0xFF) sent with in_valid held high, followed by 0x00 -> two frames with parity 0 each, separated by exactly one idle-high cycle.
REQ-033 Toggle s/e/f every cycle during a frame -> the transmitted bits match the byte captured at accept.
REQ-034 Assert rst during DATA bit 3 -> tx=1 immediately, no frame_done; the next word is accepted correctly after release.
REQ-035 CLKS_PER_BIT=1; byte 0xA5 -> 11 consecutive single-cycle bits 0,1,0,1,0,0,1,0,1,0,1.
